phy_read_burst_fifo: RTL and testbench
======================================

# phy_read_burst_fifo

Parametrised PHY read-data buffer, successor to the single-channel PHY read path in the backend. It captures DQ read beats at burst granularity with per-burst tags and optional burst-chop (BC4). Bursts are stored in a multi-slot store-and-forward FIFO. Complete bursts stream toward the Read Buffer with valid/ready flow control, LAST marking, occupancy reporting and sticky error flags.

## Interface
- MEM_DATAWIDTH, 64, width of one DQ beat
- BURST_LENGTH, 8, beats per full burst; power of two, 4..16
- FIFO_BURSTS, 4, burst slots of storage; power of two, >= 2
- TAG_WIDTH, 4, width of per-burst read tag

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  one DQ beat present this cycle
- in_start  in  1  qualifies first beat of a burst (meaningful only with in_valid)
- in_chop  in  1  sampled with in_start; 1 = BC4 (BURST_LENGTH/2 beats)
- in_tag  in  TAG_WIDTH  sampled with in_start
- in_data  in  MEM_DATAWIDTH  beat data
- read_ack  out  1  one-cycle pulse: a burst completed capture
- ack_tag  out  TAG_WIDTH  tag of the completed burst, valid with read_ack
- out_valid  out  1  beat available to Read Buffer
- out_ready  in  1  Read Buffer accepts beat
- out_data  out  MEM_DATAWIDTH  beat data
- out_last  out  1  final beat of current burst
- out_tag  out  TAG_WIDTH  tag of burst being streamed
- level  out  $clog2(FIFO_BURSTS+1)  number of complete bursts stored
- overflow  out  1  sticky: burst dropped because no free slot
- proto_err  out  1  sticky: capture protocol violation

## Operation
- Storage: FIFO_BURSTS slots × BURST_LENGTH beats, plus per-slot tag and chop bit. Write side has slot pointer + beat index. Read side has slot pointer + beat index. Burst length is BURST_LENGTH, or BURST_LENGTH/2 when chopped.
- Capture states: IDLE, FILL, DROP.
  - IDLE + in_valid&in_start + free slot: write beat 0, latch tag/chop, go FILL. A 1-beat burst is impossible, since BURST_LENGTH >= 4.
  - IDLE + in_valid&in_start + no free slot: set overflow, go DROP.
  - IDLE + in_valid & !in_start: set proto_err, discard beat, stay IDLE.
  - FILL + in_valid & !in_start: write beat at index. On index == len-1: mark slot complete, advance slot pointer, pulse read_ack, go IDLE.
  - FILL + in_valid & in_start: set proto_err, abandon the partial burst (slot stays free), restart the same slot with this beat as beat 0.
  - DROP: count beats of the dropped burst (length from in_chop sampled at its start), return to IDLE after its last beat. No writes. in_start inside DROP: set proto_err, restart the count.
- A free slot is a slot neither complete nor being filled. A slot is free again the cycle after its last beat is popped.
- Read side, first-word-fall-through:
  - out_valid = level != 0.
  - out_data/out_tag come combinationally from the read slot/beat.
  - out_last = (read beat index == len-1 of the read slot).
  - A pop (out_valid & out_ready) advances the beat index. The pop with out_last frees the slot, advances the read slot pointer and resets the beat index.
- level: +1 on burst completion, −1 on last-beat pop. Both in the same cycle leaves level unchanged. Never exceeds FIFO_BURSTS.
- Pointers wrap modulo FIFO_BURSTS and BURST_LENGTH; no extra bit is needed because level/free tracking is explicit.
- out_data is 0 when out_valid is 0.

## Timing
- Reset (rst=1 at a clk edge) clears all outputs to 0: read_ack, ack_tag, out_valid, out_data, out_last, out_tag, level, overflow, proto_err. It also clears pointers, returns to IDLE and discards stored and partial bursts. Reset mid-burst drops the burst with no ack.
- Last capture beat at edge N gives read_ack=1 and ack_tag for cycle N+1 only. level increments visible at N+1. With the FIFO previously empty, out_valid rises at N+1.
- Throughput: 1 beat/cycle in, 1 beat/cycle out, concurrently. Back-to-back bursts need no idle cycle.
- Freed slot is usable by an in_start at edge N+1 after the last-beat pop at edge N. A start in the same edge as the freeing pop with no other free slot overflows.
- out_* remain stable while out_valid & !out_ready.
- Sticky flags are cleared only by rst.

## Test plan
- Single full burst, BURST_LENGTH=8, tag 3, data 0x10..0x17, out_ready=1 → read_ack one cycle after beat 7 with ack_tag=3. 8 beats out 0x10..0x17, out_last on 0x17 only, level 0→1→0.
- BC4 burst, tag 5, 4 beats 0xA0..0xA3 → ack after 4th beat. 4 beats out with out_last on 0xA3, then out_valid=0.
- out_ready=0, five back-to-back 8-beat bursts with FIFO_BURSTS=4 → four acks, level=4, 5th burst dropped with no ack and overflow=1. Then draining yields exactly bursts 1-4 in order with correct tags.
- Fill and drain simultaneously: level=2, a completion and a last-beat pop land on the same edge → level stays 2 and order is preserved.
- in_start on beat 3 of a burst → proto_err=1, no ack for the abandoned burst, the new burst is captured and acked normally. in_valid without in_start in IDLE → proto_err, nothing stored.
- rst asserted mid-burst while level=2 → next cycle all outputs 0. Subsequent burst captured into slot 0 and acked normally.

Source files
------------

// File: rtl/phy_read_burst_fifo.sv
// PHY read-data burst buffer: captures tagged DQ bursts (full or BC4) into slot storage, streams complete bursts out FWFT.
// Latency: read_ack and level update one cycle after the last capture beat; output is first-word-fall-through.
// Backpressure: out_valid/out_ready on the read side; no input stall, so bursts arriving with no free slot are dropped (overflow).
module phy_read_burst_fifo #(
    parameter int MEM_DATAWIDTH = 64,
    parameter int BURST_LENGTH  = 8,
    parameter int FIFO_BURSTS   = 4,
    parameter int TAG_WIDTH     = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic                             in_start,
    input  logic                             in_chop,
    input  logic [TAG_WIDTH-1:0]             in_tag,
    input  logic [MEM_DATAWIDTH-1:0]         in_data,
    output logic                             read_ack,
    output logic [TAG_WIDTH-1:0]             ack_tag,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [MEM_DATAWIDTH-1:0]         out_data,
    output logic                             out_last,
    output logic [TAG_WIDTH-1:0]             out_tag,
    output logic [$clog2(FIFO_BURSTS+1)-1:0] level,
    output logic                             overflow,
    output logic                             proto_err
);
    localparam int SLOT_W = $clog2(FIFO_BURSTS);
    localparam int BEAT_W = $clog2(BURST_LENGTH);
    localparam int LVL_W  = $clog2(FIFO_BURSTS+1);
    localparam logic [BEAT_W-1:0] FULL_LAST = BEAT_W'(BURST_LENGTH-1);
    localparam logic [BEAT_W-1:0] HALF_LAST = BEAT_W'(BURST_LENGTH/2-1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DROP} state_t;

    state_t                 state_q, state_d;
    logic [SLOT_W-1:0]      wr_slot_q, wr_slot_d, rd_slot_q, rd_slot_d;
    logic [BEAT_W-1:0]      wr_beat_q, wr_beat_d, rd_beat_q, rd_beat_d;
    logic [BEAT_W-1:0]      drop_cnt_q, drop_cnt_d;
    logic                   drop_chop_q, drop_chop_d;
    logic [FIFO_BURSTS-1:0] complete_q, complete_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic                   read_ack_q, read_ack_d;
    logic [TAG_WIDTH-1:0]   ack_tag_q, ack_tag_d;
    logic                   overflow_q, overflow_d;
    logic                   proto_err_q, proto_err_d;

    logic [MEM_DATAWIDTH-1:0] data_mem [FIFO_BURSTS][BURST_LENGTH];
    logic [TAG_WIDTH-1:0]     tag_mem  [FIFO_BURSTS];
    logic [FIFO_BURSTS-1:0]   chop_mem;

    logic              mem_we, hdr_we, burst_done, pop, last_pop, rd_at_last;
    logic [BEAT_W-1:0] mem_beat, fill_last, drop_last, rd_last;

    assign fill_last  = chop_mem[wr_slot_q] ? HALF_LAST : FULL_LAST;
    assign drop_last  = drop_chop_q ? HALF_LAST : FULL_LAST;
    assign rd_last    = chop_mem[rd_slot_q] ? HALF_LAST : FULL_LAST;
    assign rd_at_last = (rd_beat_q == rd_last);
    assign out_valid  = (level_q != '0);
    assign pop        = out_valid & out_ready;
    assign last_pop   = pop & rd_at_last;

    always_comb begin
        state_d     = state_q;
        wr_slot_d   = wr_slot_q;
        wr_beat_d   = wr_beat_q;
        rd_slot_d   = rd_slot_q;
        rd_beat_d   = rd_beat_q;
        drop_cnt_d  = drop_cnt_q;
        drop_chop_d = drop_chop_q;
        complete_d  = complete_q;
        level_d     = level_q;
        read_ack_d  = 1'b0;
        ack_tag_d   = '0;
        overflow_d  = overflow_q;
        proto_err_d = proto_err_q;
        mem_we      = 1'b0;
        hdr_we      = 1'b0;
        mem_beat    = wr_beat_q;
        burst_done  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_start) begin
                    // The write slot is the only candidate; it is free iff not holding a complete burst.
                    if (!complete_q[wr_slot_q]) begin
                        mem_we    = 1'b1;
                        hdr_we    = 1'b1;
                        mem_beat  = '0;
                        wr_beat_d = BEAT_W'(1);
                        state_d   = S_FILL;
                    end else begin
                        overflow_d  = 1'b1;
                        drop_chop_d = in_chop;
                        drop_cnt_d  = BEAT_W'(1);
                        state_d     = S_DROP;
                    end
                end else if (in_valid) begin
                    proto_err_d = 1'b1;
                end
            end
            S_FILL: begin
                if (in_valid && in_start) begin
                    proto_err_d = 1'b1;
                    mem_we      = 1'b1;
                    hdr_we      = 1'b1;
                    mem_beat    = '0;
                    wr_beat_d   = BEAT_W'(1);
                end else if (in_valid) begin
                    mem_we = 1'b1;
                    if (wr_beat_q == fill_last) begin
                        burst_done = 1'b1;
                        read_ack_d = 1'b1;
                        ack_tag_d  = tag_mem[wr_slot_q];
                        wr_beat_d  = '0;
                        wr_slot_d  = wr_slot_q + 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        wr_beat_d = wr_beat_q + 1'b1;
                    end
                end
            end
            S_DROP: begin
                if (in_valid && in_start) begin
                    proto_err_d = 1'b1;
                    drop_chop_d = in_chop;
                    drop_cnt_d  = BEAT_W'(1);
                end else if (in_valid) begin
                    if (drop_cnt_q == drop_last) begin
                        state_d = S_IDLE;
                    end else begin
                        drop_cnt_d = drop_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            if (rd_at_last) begin
                rd_beat_d             = '0;
                rd_slot_d             = rd_slot_q + 1'b1;
                complete_d[rd_slot_q] = 1'b0;
            end else begin
                rd_beat_d = rd_beat_q + 1'b1;
            end
        end
        if (burst_done) begin
            complete_d[wr_slot_q] = 1'b1;
        end
        if (burst_done && !last_pop) begin
            level_d = level_q + 1'b1;
        end else if (!burst_done && last_pop) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_slot_q   <= '0;
            wr_beat_q   <= '0;
            rd_slot_q   <= '0;
            rd_beat_q   <= '0;
            drop_cnt_q  <= '0;
            drop_chop_q <= 1'b0;
            complete_q  <= '0;
            level_q     <= '0;
            read_ack_q  <= 1'b0;
            ack_tag_q   <= '0;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_slot_q   <= wr_slot_d;
            wr_beat_q   <= wr_beat_d;
            rd_slot_q   <= rd_slot_d;
            rd_beat_q   <= rd_beat_d;
            drop_cnt_q  <= drop_cnt_d;
            drop_chop_q <= drop_chop_d;
            complete_q  <= complete_d;
            level_q     <= level_d;
            read_ack_q  <= read_ack_d;
            ack_tag_q   <= ack_tag_d;
            overflow_q  <= overflow_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Storage needs no reset: every read is gated by a complete-slot count.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            data_mem[wr_slot_q][mem_beat] <= in_data;
        end
        if (hdr_we) begin
            tag_mem[wr_slot_q]  <= in_tag;
            chop_mem[wr_slot_q] <= in_chop;
        end
    end

    assign read_ack  = read_ack_q;
    assign ack_tag   = ack_tag_q;
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign proto_err = proto_err_q;
    assign out_data  = out_valid ? data_mem[rd_slot_q][rd_beat_q] : '0;
    assign out_tag   = out_valid ? tag_mem[rd_slot_q] : '0;
    assign out_last  = out_valid & rd_at_last;
endmodule

// File: tb/tb_phy_read_burst_fifo.sv
// Bench for phy_read_burst_fifo: directed scenarios plus randomized traffic against a queue-based burst model.
module tb_phy_read_burst_fifo;
    localparam int MW = 64;
    localparam int BL = 8;
    localparam int FB = 4;
    localparam int TW = 4;
    localparam int LW = $clog2(FB+1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0, in_start = 1'b0, in_chop = 1'b0, out_ready = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic [MW-1:0] in_data = '0;
    logic          read_ack, out_valid, out_last, overflow, proto_err;
    logic [TW-1:0] ack_tag, out_tag;
    logic [MW-1:0] out_data;
    logic [LW-1:0] level;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    phy_read_burst_fifo #(.MEM_DATAWIDTH(MW), .BURST_LENGTH(BL), .FIFO_BURSTS(FB), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_start(in_start), .in_chop(in_chop),
        .in_tag(in_tag), .in_data(in_data), .read_ack(read_ack), .ack_tag(ack_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .out_tag(out_tag), .level(level), .overflow(overflow), .proto_err(proto_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic c, input logic [TW-1:0] t, input logic [MW-1:0] d);
        in_valid = v; in_start = s; in_chop = c; in_tag = t; in_data = d;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, '0, '0);
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({read_ack, ack_tag, out_valid, out_data, out_last, out_tag, level, overflow, proto_err} !== '0) begin
            bad++; $display("FAIL reset_outputs got=%h required=0", {read_ack, ack_tag, out_valid, out_data, out_last, out_tag, level, overflow, proto_err});
        end
        tick();
        total++;
        if (out_valid !== 1'b0 || level !== '0) begin
            bad++; $display("FAIL reset_idle got valid=%b level=%0d required 0/0", out_valid, level);
        end
    endtask

    task automatic test_single_burst();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1, i == 0, 0, 4'd3, MW'(16 + i));
            tick();
            if (i < 7) begin
                total++;
                if (read_ack !== 1'b0) begin bad++; $display("FAIL single_early_ack beat=%0d got=%b required=0", i, read_ack); end
            end
        end
        drive(0, 0, 0, '0, '0);
        total++;
        if (read_ack !== 1'b1 || ack_tag !== 4'd3) begin bad++; $display("FAIL single_ack got=%b/%0d required=1/3", read_ack, ack_tag); end
        total++;
        if (level !== LW'(1) || out_valid !== 1'b1) begin bad++; $display("FAIL single_level got=%0d/%b required=1/1", level, out_valid); end
        for (int j = 0; j < 8; j++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== MW'(16 + j) || out_last !== (j == 7) || out_tag !== 4'd3) begin
                bad++; $display("FAIL single_beat j=%0d got v=%b d=%h l=%b t=%0d required v=1 d=%h l=%b t=3", j, out_valid, out_data, out_last, out_tag, 16 + j, j == 7);
            end
            if (j == 1) begin
                total++;
                if (read_ack !== 1'b0) begin bad++; $display("FAIL single_ack_pulse got=%b required=0", read_ack); end
            end
            tick();
        end
        total++;
        if (out_valid !== 1'b0 || level !== '0 || out_data !== '0) begin
            bad++; $display("FAIL single_empty got v=%b level=%0d d=%h required 0/0/0", out_valid, level, out_data);
        end
    endtask

    task automatic test_bc4();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1, i == 0, i == 0, 4'd5, MW'(8'hA0 + i));
            tick();
        end
        drive(0, 0, 0, '0, '0);
        total++;
        if (read_ack !== 1'b1 || ack_tag !== 4'd5) begin bad++; $display("FAIL bc4_ack got=%b/%0d required=1/5", read_ack, ack_tag); end
        for (int j = 0; j < 4; j++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== MW'(8'hA0 + j) || out_last !== (j == 3)) begin
                bad++; $display("FAIL bc4_beat j=%0d got v=%b d=%h l=%b required v=1 d=%h l=%b", j, out_valid, out_data, out_last, 8'hA0 + j, j == 3);
            end
            tick();
        end
        total++;
        if (out_valid !== 1'b0 || level !== '0) begin bad++; $display("FAIL bc4_empty got v=%b level=%0d required 0/0", out_valid, level); end
    endtask

    task automatic test_overflow();
        int acks;
        do_reset();
        acks = 0;
        for (int b = 1; b <= 5; b++) begin
            for (int i = 0; i < 8; i++) begin
                drive(1, i == 0, 0, TW'(b), MW'(b * 16 + i));
                tick();
                if (read_ack === 1'b1) acks++;
            end
        end
        drive(0, 0, 0, '0, '0);
        total++;
        if (acks != 4) begin bad++; $display("FAIL ovf_ack_count got=%0d required=4", acks); end
        total++;
        if (level !== LW'(4) || overflow !== 1'b1 || proto_err !== 1'b0) begin
            bad++; $display("FAIL ovf_state got level=%0d ovf=%b perr=%b required 4/1/0", level, overflow, proto_err);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 32; k++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== MW'((k / 8 + 1) * 16 + k % 8) || out_tag !== TW'(k / 8 + 1) || out_last !== (k % 8 == 7)) begin
                bad++; $display("FAIL ovf_drain k=%0d got d=%h t=%0d l=%b required d=%h t=%0d l=%b", k, out_data, out_tag, out_last, (k / 8 + 1) * 16 + k % 8, k / 8 + 1, k % 8 == 7);
            end
            tick();
        end
        total++;
        if (out_valid !== 1'b0 || overflow !== 1'b1) begin bad++; $display("FAIL ovf_after got v=%b ovf=%b required 0/1", out_valid, overflow); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int b = 1; b <= 2; b++)
            for (int i = 0; i < 8; i++) begin
                drive(1, i == 0, 0, TW'(b), MW'(b * 16 + i));
                tick();
            end
        drive(0, 0, 0, '0, '0);
        tick();
        total++;
        if (level !== LW'(2)) begin bad++; $display("FAIL b2b_level_pre got=%0d required=2", level); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1, i == 0, 0, 4'd3, MW'(48 + i));
            tick();
            total++;
            if (level !== LW'(2)) begin bad++; $display("FAIL b2b_level i=%0d got=%0d required=2", i, level); end
        end
        drive(0, 0, 0, '0, '0);
        total++;
        if (read_ack !== 1'b1 || ack_tag !== 4'd3) begin bad++; $display("FAIL b2b_ack got=%b/%0d required=1/3", read_ack, ack_tag); end
        for (int k = 0; k < 16; k++) begin
            total++;
            if (out_valid !== 1'b1 || out_tag !== TW'(k / 8 + 2) || out_data !== MW'((k / 8 + 2) * 16 + k % 8)) begin
                bad++; $display("FAIL b2b_drain k=%0d got t=%0d d=%h required t=%0d d=%h", k, out_tag, out_data, k / 8 + 2, (k / 8 + 2) * 16 + k % 8);
            end
            tick();
        end
        total++;
        if (out_valid !== 1'b0 || overflow !== 1'b0 || proto_err !== 1'b0) begin
            bad++; $display("FAIL b2b_end got v=%b ovf=%b perr=%b required 0/0/0", out_valid, overflow, proto_err);
        end
    endtask

    task automatic test_proto();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, i == 0, 0, 4'd7, MW'(8'h70 + i));
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            drive(1, i == 0, 0, 4'd9, MW'(8'h90 + i));
            tick();
            if (i == 0) begin
                total++;
                if (proto_err !== 1'b1) begin bad++; $display("FAIL proto_restart got=%b required=1", proto_err); end
            end
            if (i < 7) begin
                total++;
                if (read_ack !== 1'b0) begin bad++; $display("FAIL proto_no_ack i=%0d got=%b required=0", i, read_ack); end
            end
        end
        drive(0, 0, 0, '0, '0);
        total++;
        if (read_ack !== 1'b1 || ack_tag !== 4'd9) begin bad++; $display("FAIL proto_ack got=%b/%0d required=1/9", read_ack, ack_tag); end
        for (int j = 0; j < 8; j++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== MW'(8'h90 + j) || out_tag !== 4'd9) begin
                bad++; $display("FAIL proto_drain j=%0d got d=%h t=%0d required d=%h t=9", j, out_data, out_tag, 8'h90 + j);
            end
            tick();
        end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL proto_empty got=%b required=0", out_valid); end
        do_reset();
        drive(1, 0, 0, 4'd1, 64'hDEAD);
        tick();
        drive(0, 0, 0, '0, '0);
        total++;
        if (proto_err !== 1'b1 || level !== '0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL proto_stray got perr=%b level=%0d v=%b required 1/0/0", proto_err, level, out_valid);
        end
        tick();
        total++;
        if (level !== '0 || read_ack !== 1'b0) begin bad++; $display("FAIL proto_stray_after got level=%0d ack=%b required 0/0", level, read_ack); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int b = 1; b <= 2; b++)
            for (int i = 0; i < 8; i++) begin
                drive(1, i == 0, 0, TW'(b), MW'(b * 16 + i));
                tick();
            end
        for (int i = 0; i < 3; i++) begin
            drive(1, i == 0, 0, 4'd3, MW'(48 + i));
            tick();
        end
        total++;
        if (level !== LW'(2)) begin bad++; $display("FAIL rstmid_pre got=%0d required=2", level); end
        drive(1, 0, 0, 4'd3, MW'(51));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 0, 0, '0, '0);
        total++;
        if ({read_ack, ack_tag, out_valid, out_data, out_last, out_tag, level, overflow, proto_err} !== '0) begin
            bad++; $display("FAIL rstmid_outputs got=%h required=0", {read_ack, ack_tag, out_valid, out_data, out_last, out_tag, level, overflow, proto_err});
        end
        for (int i = 0; i < 8; i++) begin
            drive(1, i == 0, 0, 4'd6, MW'(8'h60 + i));
            tick();
        end
        drive(0, 0, 0, '0, '0);
        total++;
        if (read_ack !== 1'b1 || ack_tag !== 4'd6 || level !== LW'(1)) begin
            bad++; $display("FAIL rstmid_ack got ack=%b tag=%0d level=%0d required 1/6/1", read_ack, ack_tag, level);
        end
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            total++;
            if (out_data !== MW'(8'h60 + j) || out_tag !== 4'd6 || out_last !== (j == 7)) begin
                bad++; $display("FAIL rstmid_drain j=%0d got d=%h t=%0d l=%b required d=%h t=6 l=%b", j, out_data, out_tag, out_last, 8'h60 + j, j == 7);
            end
            tick();
        end
    endtask

    typedef struct packed {
        logic [TW-1:0]         tag;
        logic [4:0]            len;
        logic [BL-1:0][MW-1:0] d;
    } burst_t;

    task automatic test_random();
        burst_t        mq[$];
        burst_t        cur;
        int            m_st, m_cnt, m_dlen, m_rd, g_rem, r;
        bit            m_ovf, m_perr, m_ack, pop, lastpop, done;
        logic [TW-1:0] m_ack_tag;
        logic          v, s, c, rdy;
        logic [TW-1:0] t;
        logic [MW-1:0] d;
        logic [MW-1:0] exp_d;
        do_reset();
        m_st = 0; m_cnt = 0; m_dlen = 0; m_rd = 0; g_rem = 0;
        m_ovf = 0; m_perr = 0; m_ack = 0; m_ack_tag = '0; cur = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r = int'($urandom_range(0, 99));
            v = 0; s = 0; c = 1'($urandom_range(0, 1));
            t = TW'($urandom); d = {$urandom, $urandom};
            if (g_rem == 0) begin
                if (r < 55) begin v = 1; s = 1; g_rem = (c ? BL / 2 : BL) - 1; end
                else if (r < 58) v = 1;
            end else begin
                if (r < 80) begin v = 1; g_rem--; end
                else if (r < 83) begin v = 1; s = 1; g_rem = (c ? BL / 2 : BL) - 1; end
            end
            case ((cyc / 200) % 3)
                0:       rdy = ($urandom_range(0, 9) != 0);
                1:       rdy = ($urandom_range(0, 9) == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            drive(v, s, c, t, d);
            out_ready = rdy;

            pop = (mq.size() != 0) && rdy;
            lastpop = pop && (m_rd == int'(mq[0].len) - 1);
            m_ack = 0; done = 0;
            if (v) begin
                if (s && (m_st == 1 || (m_st == 0 && mq.size() < FB))) begin
                    if (m_st == 1) m_perr = 1;
                    cur = '0; cur.tag = t; cur.len = c ? 5'(BL / 2) : 5'(BL); cur.d[0] = d;
                    m_cnt = 1; m_st = 1;
                end else if (s) begin
                    if (m_st == 0) m_ovf = 1; else m_perr = 1;
                    m_dlen = c ? BL / 2 : BL; m_cnt = 1; m_st = 2;
                end else if (m_st == 0) begin
                    m_perr = 1;
                end else if (m_st == 1) begin
                    cur.d[m_cnt] = d; m_cnt++;
                    if (m_cnt == int'(cur.len)) begin done = 1; m_ack = 1; m_ack_tag = cur.tag; m_st = 0; end
                end else begin
                    m_cnt++;
                    if (m_cnt == m_dlen) m_st = 0;
                end
            end
            if (lastpop) begin void'(mq.pop_front()); m_rd = 0; end
            else if (pop) m_rd++;
            if (done) mq.push_back(cur);

            tick();

            exp_d = (mq.size() != 0) ? mq[0].d[m_rd] : '0;
            total++;
            if (out_valid !== (mq.size() != 0)) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b required=%b", cyc, out_valid, mq.size() != 0); end
            total++;
            if (level !== LW'(mq.size())) begin bad++; $display("FAIL rnd_level cyc=%0d got=%0d required=%0d", cyc, level, mq.size()); end
            total++;
            if (out_data !== exp_d) begin bad++; $display("FAIL rnd_data cyc=%0d got=%h required=%h", cyc, out_data, exp_d); end
            if (mq.size() != 0) begin
                total++;
                if (out_tag !== mq[0].tag || out_last !== (m_rd == int'(mq[0].len) - 1)) begin
                    bad++; $display("FAIL rnd_tag_last cyc=%0d got t=%0d l=%b required t=%0d l=%b", cyc, out_tag, out_last, mq[0].tag, m_rd == int'(mq[0].len) - 1);
                end
            end
            total++;
            if (read_ack !== m_ack) begin bad++; $display("FAIL rnd_ack cyc=%0d got=%b required=%b", cyc, read_ack, m_ack); end
            if (m_ack) begin
                total++;
                if (ack_tag !== m_ack_tag) begin bad++; $display("FAIL rnd_ack_tag cyc=%0d got=%0d required=%0d", cyc, ack_tag, m_ack_tag); end
            end
            total++;
            if (overflow !== m_ovf || proto_err !== m_perr) begin
                bad++; $display("FAIL rnd_flags cyc=%0d got ovf=%b perr=%b required ovf=%b perr=%b", cyc, overflow, proto_err, m_ovf, m_perr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_bc4();
        test_overflow();
        test_back_to_back();
        test_proto();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
